// File: rtl/mips_bus_arbiter_pkg.sv
// Shared constants for the multi-master data bus arbiter.
package mips_bus_arbiter_pkg;

  // Arbiter FSM encodings
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_HOLD = 2'd2;

  // Width of a master index; a single master still needs one bit to name it
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester cyclically after `last`.
module rr_picker
  import mips_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = arb_idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic                 vld,
  output logic [IDX_W-1:0]     idx
);

  int c;

  // Scan distances 1..N from last; the first hit has the lowest cyclic distance
  always_comb begin
    vld = 1'b0;
    idx = '0;
    c   = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      c = (int'(last) + k) % N_MASTERS;
      if (!vld && req[c]) begin
        vld = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// N-master data bus arbiter: round-robin grant, locked bursts bounded by LOCK_MAX.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter string TAG        = "mips_bus_arbiter",
  parameter int    N_MASTERS  = 2,
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 32,
  parameter int    LOCK_MAX   = 16
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic [N_MASTERS-1:0]             m_re,
  input  logic [N_MASTERS-1:0]             m_we,
  input  logic [N_MASTERS-1:0]             m_io,
  input  logic [N_MASTERS-1:0]             m_lock,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_dataOut,
  output logic [DATA_WIDTH-1:0]            m_dataIn,
  output logic [N_MASTERS-1:0]             m_ready,
  output logic [N_MASTERS-1:0]             m_grant,
  output logic                             db_re,
  output logic                             db_we,
  output logic                             db_io,
  output logic [ADDR_WIDTH-1:0]            db_addr,
  output logic [DATA_WIDTH-1:0]            db_dataOut,
  input  logic [DATA_WIDTH-1:0]            db_dataIn,
  input  logic                             db_ready
);

  localparam int IDX_W = arb_idx_w(N_MASTERS);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] data_a;
  logic [N_MASTERS-1:0]                 req;

  logic [1:0]       state;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] last;
  logic [CNT_W-1:0] lock_cnt;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             req_g;
  logic             done;

  assign addr_a = m_addr;
  assign data_a = m_dataOut;
  assign req    = m_re | m_we;
  assign req_g  = req[g];
  // A completion needs an active bus cycle; reset in the same cycle swallows it
  assign done   = (state == ARB_BUSY) && req_g && db_ready && res;

  assign m_dataIn = db_dataIn;

  rr_picker #(.N_MASTERS(N_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req  (req),
    .last (last),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Arbiter FSM: owner, round-robin pointer and lock burst length
  always_ff @(posedge clk) begin
    if (!res) begin
      state    <= ARB_IDLE;
      g        <= '0;
      last     <= IDX_W'(N_MASTERS - 1);
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state    <= ARB_BUSY;
            g        <= pick_idx;
            lock_cnt <= '0;
          end
        end
        ARB_BUSY: begin
          if (!req_g) begin
            state <= ARB_IDLE;
          end else if (done) begin
            last <= g;
            if (m_lock[g] && (lock_cnt < CNT_W'(LOCK_MAX - 1))) begin
              state    <= ARB_HOLD;
              lock_cnt <= lock_cnt + CNT_W'(1);
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        ARB_HOLD: state <= req_g ? ARB_BUSY : ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  // Output mux: owner drives the bus only while BUSY; grant persists through HOLD
  always_comb begin
    db_re      = 1'b0;
    db_we      = 1'b0;
    db_io      = 1'b0;
    db_addr    = '0;
    db_dataOut = '0;
    m_ready    = '0;
    m_grant    = '0;
    if (state == ARB_BUSY || state == ARB_HOLD) m_grant[g] = 1'b1;
    if (state == ARB_BUSY) begin
      db_we      = m_we[g];
      db_re      = m_re[g] & ~m_we[g];
      db_io      = m_io[g];
      db_addr    = addr_a[g];
      db_dataOut = data_a[g];
      m_ready[g] = done;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed table-driven bench for mips_bus_arbiter (4 masters, LOCK_MAX=4).
module tb_mips_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            res;
  logic [N-1:0]    m_re, m_we, m_io, m_lock;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dataOut;
  logic [DW-1:0]   m_dataIn;
  logic [N-1:0]    m_ready, m_grant;
  logic            db_re, db_we, db_io;
  logic [AW-1:0]   db_addr;
  logic [DW-1:0]   db_dataOut, db_dataIn;
  logic            db_ready;

  mips_bus_arbiter #(
    .TAG("tb_arb"), .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(4)
  ) dut (
    .clk(clk), .res(res),
    .m_re(m_re), .m_we(m_we), .m_io(m_io), .m_lock(m_lock),
    .m_addr(m_addr), .m_dataOut(m_dataOut), .m_dataIn(m_dataIn),
    .m_ready(m_ready), .m_grant(m_grant),
    .db_re(db_re), .db_we(db_we), .db_io(db_io),
    .db_addr(db_addr), .db_dataOut(db_dataOut),
    .db_dataIn(db_dataIn), .db_ready(db_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] A [N];
  logic [31:0] D [N];

  typedef struct {
    logic       res;
    logic [3:0] re, we, io, lock;
    logic       rdy;
    logic [3:0] e_grant, e_ready;
    logic       e_re, e_we, e_io;
    int         own;  // master whose addr/data show on db_*, -1 = none
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] re, input logic [3:0] we,
                              input logic [3:0] io, input logic [3:0] lk, input logic rdy,
                              input logic [3:0] eg, input logic [3:0] er, input logic ere,
                              input logic ewe, input logic eio, input int own);
    vec_t v;
    v.res = r; v.re = re; v.we = we; v.io = io; v.lock = lk; v.rdy = rdy;
    v.e_grant = eg; v.e_ready = er; v.e_re = ere; v.e_we = ewe; v.e_io = eio; v.own = own;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [127:0] act_v, exp_v;
  logic [31:0]  e_addr, e_data;

  initial begin
    A[0] = 32'h0000_1000; A[1] = 32'h0000_2000; A[2] = 32'h1000_0040; A[3] = 32'h0000_4000;
    D[0] = 32'h1111_0000; D[1] = 32'h2222_0000; D[2] = 32'hDEAD_BEEF; D[3] = 32'h4444_0000;
    m_addr    = {A[3], A[2], A[1], A[0]};
    m_dataOut = {D[3], D[2], D[1], D[0]};

    //                  res re     we     io     lock   rdy grant  ready  re we io own
    // reset state, then reset priority: 0 before 1
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h0, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h2, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h2, 4'h0, 4'h0, 4'h0, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    // reset, then round-robin 0,1,2,3,0 with an idle cycle between grants
    vq.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h4, 4'h4, 1, 0, 0, 2));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h8, 4'h8, 1, 0, 0, 3));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    // locked fill by master 1 (4 transfers) while master 0 waits
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h3, 4'h0, 4'h0, 4'h2, 1, 4'h1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h2, 4'h0, 4'h0, 4'h2, 1, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h2, 4'h0, 4'h0, 4'h2, 1, 4'h2, 4'h2, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h2, 0, 4'h2, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    // abort by master 0: no ready, last stays 1 so master 2 wins next
    vq.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h0, 0, 0, 0, 0));
    // master 2 IO write of DEAD_BEEF to 1000_0040 while others request
    vq.push_back(mk(1, 4'hB, 4'h4, 4'h4, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'hB, 4'h4, 4'h4, 4'h0, 0, 4'h4, 4'h0, 0, 1, 1, 2));
    vq.push_back(mk(1, 4'hB, 4'h4, 4'h4, 4'h0, 0, 4'h4, 4'h0, 0, 1, 1, 2));
    vq.push_back(mk(1, 4'hB, 4'h4, 4'h4, 4'h0, 1, 4'h4, 4'h4, 0, 1, 1, 2));
    // master 3 write, reset mid-transfer, master 0 regains priority
    vq.push_back(mk(1, 4'h0, 4'h8, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h0, 4'h8, 4'h0, 4'h0, 0, 4'h8, 4'h0, 0, 1, 0, 3));
    vq.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h0, 1, 4'h8, 4'h0, 0, 1, 0, 3));
    vq.push_back(mk(1, 4'h1, 4'h8, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));
    vq.push_back(mk(1, 4'h1, 4'h8, 4'h0, 4'h0, 0, 4'h1, 4'h0, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h1, 4'h8, 4'h0, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, -1));

    res = 1'b0; m_re = '0; m_we = '0; m_io = '0; m_lock = '0;
    db_ready = 1'b0; db_dataIn = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      res = vq[i].res; m_re = vq[i].re; m_we = vq[i].we; m_io = vq[i].io;
      m_lock = vq[i].lock; db_ready = vq[i].rdy; db_dataIn = 32'hC0DE_0000 + i;
      #1;
      e_addr = (vq[i].own >= 0) ? A[vq[i].own] : 32'h0;
      e_data = (vq[i].own >= 0) ? D[vq[i].own] : 32'h0;
      act_v = {13'h0, m_grant, m_ready, db_re, db_we, db_io, db_addr, db_dataOut, m_dataIn};
      exp_v = {13'h0, vq[i].e_grant, vq[i].e_ready, vq[i].e_re, vq[i].e_we, vq[i].e_io,
               e_addr, e_data, 32'hC0DE_0000 + i};
      check($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Read+write asserted together by master 1 behaves as a write; slow slave
    @(negedge clk);
    m_re = 4'h2; m_we = 4'h2; m_io = '0; m_lock = '0; db_ready = 1'b0;
    #1;
    for (int k = 0; k < 4 && m_grant != 4'h2; k++) begin
      @(negedge clk); #1;
    end
    check("rw_grant", {124'h0, m_grant}, {124'h0, 4'h2});
    check("rw_as_write", {126'h0, db_re, db_we}, {126'h0, 2'b01});
    check("rw_wait_noready", {124'h0, m_ready}, 128'h0);
    repeat (3) begin
      @(negedge clk); #1;
    end
    check("rw_held", {92'h0, m_grant, db_addr}, {92'h0, 4'h2, A[1]});
    db_ready = 1'b1;
    #1;
    check("rw_ready", {124'h0, m_ready}, {124'h0, 4'h2});
    @(negedge clk);
    m_re = '0; m_we = '0; db_ready = 1'b0;
    #1;
    check("rw_release", {120'h0, m_grant, m_ready}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
